// File: rtl/audio_timer_sequencer.sv
// audio_timer_sequencer: programs an interval timer over its register bus and
// turns each timeout into a sample-request tick, counting ticks lost to backpressure.
module audio_timer_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        period_update,
  input  logic [31:0] period_cycles,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  output logic        tick_valid,
  input  logic        tick_ready,
  output logic        running,
  output logic        busy,
  output logic [7:0]  overrun_count
);
  typedef enum logic [2:0] {IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, STOP_WR} state_t;
  state_t state, state_nx;
  logic [31:0] load, load_nx;
  logic start_ok, update_ok, enter_ack, wr_nx;
  always_comb begin
    start_ok = state == IDLE && start;
    enter_ack = state == RUN && tmr_irq && !stop;
    update_ok = state == RUN && period_update && !tmr_irq && !stop;
    load_nx = (start_ok || update_ok) ? ((period_cycles < 32'd2) ? 32'd1 : period_cycles - 32'd1) : load;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? WR_PL : IDLE;
      WR_PL:   state_nx = WR_PH;
      WR_PH:   state_nx = WR_CTL;
      WR_CTL:  state_nx = RUN;
      RUN:     state_nx = enter_ack ? ACK : update_ok ? WR_PL : RUN;
      ACK:     state_nx = RUN;
      STOP_WR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (stop && state != IDLE && state != STOP_WR) state_nx = STOP_WR;
    wr_nx = state_nx inside {WR_PL, WR_PH, WR_CTL, ACK, STOP_WR};
  end
  // Outputs are registered from the next state so each write lines up with its state cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      load <= 32'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n <= 1'b1;
      tmr_address <= 3'd0;
      tmr_writedata <= 16'd0;
      tick_valid <= 1'b0;
      running <= 1'b0;
      busy <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      state <= state_nx;
      load <= load_nx;
      tmr_chipselect <= wr_nx;
      tmr_write_n <= !wr_nx;
      tmr_address <= state_nx == WR_PL ? 3'd2 :
                     state_nx == WR_PH ? 3'd3 :
                     (state_nx == WR_CTL || state_nx == STOP_WR) ? 3'd1 : 3'd0;
      tmr_writedata <= state_nx == WR_PL ? load_nx[15:0] :
                       state_nx == WR_PH ? load_nx[31:16] :
                       state_nx == WR_CTL ? 16'h0007 :
                       state_nx == STOP_WR ? 16'h0008 : 16'h0000;
      running <= state_nx == RUN || state_nx == ACK;
      busy <= wr_nx && state_nx != ACK;
      tick_valid <= state_nx == IDLE ? 1'b0 :
                    (enter_ack && !tick_valid) ? 1'b1 :
                    tick_ready ? 1'b0 : tick_valid;
      overrun_count <= start_ok ? 8'd0 :
                       (enter_ack && tick_valid && overrun_count != 8'hff) ? overrun_count + 8'd1 :
                       overrun_count;
    end
  end
endmodule

// File: tb/tb_audio_timer_sequencer.sv
// tb_audio_timer_sequencer: directed and randomized checks against a
// queue-of-pending-writes reference model of the timer sequencer.
module tb_audio_timer_sequencer;
  logic clk = 0, reset_n = 0, start = 0, stop = 0, period_update = 0, tmr_irq = 0, tick_ready = 0;
  logic [31:0] period_cycles = 0;
  logic [2:0] tmr_address;
  logic tmr_chipselect, tmr_write_n, tick_valid, running, busy;
  logic [15:0] tmr_writedata;
  logic [7:0] overrun_count;
  int n_chk = 0, n_fail = 0;

  audio_timer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period_update(period_update),
    .period_cycles(period_cycles), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .tick_valid(tick_valid), .tick_ready(tick_ready), .running(running), .busy(busy),
    .overrun_count(overrun_count));

  always #5 clk = ~clk;

  wire [31:0] dut_vec = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata,
                         tick_valid, running, busy, overrun_count};
  localparam logic [31:0] RESET_VEC = 32'h4000_0000;

  // Model: the timer writes still owed (head = write on the bus this cycle), whether
  // the timer is programmed, and the tick/overrun bookkeeping.
  localparam logic [1:0] K_PRG = 0, K_ACK = 1, K_STOP = 2;
  typedef struct packed {logic [1:0] k; logic [2:0] a; logic [15:0] d;} wr_t;
  wr_t mq[$];
  bit m_on;
  logic m_tv;
  logic [7:0] m_ovf;

  task automatic model_reset();
    mq.delete();
    m_on = 0;
    m_tv = 0;
    m_ovf = 0;
  endtask

  task automatic push_prog(input logic [31:0] p);
    logic [31:0] l;
    l = (p < 2) ? 32'd1 : p - 32'd1;
    mq.push_back({K_PRG, 3'd2, l[15:0]});
    mq.push_back({K_PRG, 3'd3, l[31:16]});
    mq.push_back({K_PRG, 3'd1, 16'h0007});
  endtask

  function automatic logic [31:0] exp_vec();
    logic w, run, bsy;
    logic [2:0] a;
    logic [15:0] d;
    w = mq.size() > 0;
    a = 0; d = 0; run = m_on; bsy = 0;
    if (w) begin
      a = mq[0].a;
      d = mq[0].d;
      run = m_on && mq[0].k == K_ACK;
      bsy = mq[0].k != K_ACK;
    end
    return {w, !w, a, d, m_tv, run, bsy, m_ovf};
  endfunction

  // Advance one clock: the model consumes the inputs as they stand before the edge.
  task automatic cyc();
    wr_t head;
    bit had;
    logic tv_n;
    logic [7:0] ovf_n;
    had = mq.size() > 0;
    head = had ? mq[0] : '0;
    tv_n = (m_tv && tick_ready) ? 1'b0 : m_tv;
    ovf_n = m_ovf;
    if (had) mq.delete(0);
    if (!m_on && !had) begin
      if (start) begin
        push_prog(period_cycles);
        m_on = 1;
        ovf_n = 0;
      end
    end else if (had && head.k == K_STOP) begin
      m_on = 0;
      tv_n = 0;
    end else if (stop) begin
      mq.delete();
      mq.push_back({K_STOP, 3'd1, 16'h0008});
    end else if (!had) begin
      if (tmr_irq) begin
        mq.push_back({K_ACK, 3'd0, 16'h0000});
        if (!m_tv) tv_n = 1;
        else if (m_ovf != 8'hff) ovf_n = m_ovf + 8'd1;
      end else if (period_update) push_prog(period_cycles);
    end
    m_tv = tv_n;
    m_ovf = ovf_n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %h exp %h", dut_vec, RESET_VEC);
    end
    reset_n = 1;
    tick_ready = 1;
    cyc();
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_program();
    logic [20:0] w [3];
    w[0] = {1'b1, 1'b0, 3'd2, 16'hEDFF};
    w[1] = {1'b1, 1'b0, 3'd3, 16'h0002};
    w[2] = {1'b1, 1'b0, 3'd1, 16'h0007};
    period_cycles = 32'h0002EE00;
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== w[i]) begin
        n_fail++;
        $display("FAIL prog_write%0d: got %h exp %h", i,
                 {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, w[i]);
      end
      cyc();
    end
    n_chk++;
    if ({running, busy, tmr_chipselect} !== 3'b100 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL prog_running: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_irq_ack();
    tick_ready = 1;
    tmr_irq = 1;
    cyc();
    tmr_irq = 0;
    n_chk++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, tick_valid, running} !== {2'b10, 3'd0, 16'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL ack_write: got %h exp model %h", dut_vec, exp_vec());
    end
    cyc();
    n_chk++;
    if ({tmr_chipselect, tick_valid, running, busy} !== 4'b0010 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL ack_back_to_run: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_overrun();
    tick_ready = 0;
    for (int i = 0; i < 303; i++) begin
      tmr_irq = 1;
      cyc();
      tmr_irq = 0;
      cyc();
      if (i == 2) begin
        n_chk++;
        if ({tick_valid, overrun_count} !== {1'b1, 8'd2}) begin
          n_fail++;
          $display("FAIL overrun_3irq: got tv=%b cnt=%0d exp tv=1 cnt=2", tick_valid, overrun_count);
        end
      end
    end
    n_chk++;
    if ({tick_valid, overrun_count} !== {1'b1, 8'd255} || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL overrun_saturate: got %h exp %h", dut_vec, exp_vec());
    end
    tick_ready = 1;
    cyc();
    n_chk++;
    if (tick_valid !== 1'b0 || overrun_count !== 8'd255) begin
      n_fail++;
      $display("FAIL overrun_drain: got tv=%b cnt=%0d exp tv=0 cnt=255", tick_valid, overrun_count);
    end
  endtask

  task automatic test_stop();
    stop = 1;
    cyc();
    stop = 0;
    cyc();
    stop = 1;
    cyc();
    stop = 0;
    n_chk++;
    if (dut_vec !== exp_vec() || tmr_chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_in_idle: got %h exp %h", dut_vec, exp_vec());
    end
    period_cycles = 32'd5000;
    start = 1;
    cyc();
    start = 0;
    cyc();
    stop = 1;
    cyc();
    stop = 0;
    n_chk++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy} !== {2'b10, 3'd1, 16'h0008, 1'b1}) begin
      n_fail++;
      $display("FAIL stop_write: got %h exp model %h", dut_vec, exp_vec());
    end
    cyc();
    n_chk++;
    if ({tmr_chipselect, running, tick_valid, busy} !== 4'b0000 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL stop_idle: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_update();
    logic [18:0] w [3];
    w[0] = {3'd2, 16'h0001};
    w[1] = {3'd3, 16'h0000};
    w[2] = {3'd1, 16'h0007};
    period_cycles = 32'd1000;
    start = 1;
    cyc();
    start = 0;
    repeat (3) cyc();
    period_cycles = 32'd1;
    period_update = 1;
    cyc();
    period_update = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({tmr_chipselect, tmr_address, tmr_writedata} !== {1'b1, w[i]} || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL update_write%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
      cyc();
    end
    tmr_irq = 1;
    period_update = 1;
    period_cycles = 32'd500;
    cyc();
    tmr_irq = 0;
    period_update = 0;
    n_chk++;
    if ({tmr_chipselect, tmr_address, tmr_writedata} !== {1'b1, 3'd0, 16'h0} || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL irq_beats_update: got %h exp %h", dut_vec, exp_vec());
    end
    repeat (2) cyc();
    n_chk++;
    if ({tmr_chipselect, running} !== 2'b01 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL update_dropped: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    stop = 1;
    cyc();
    stop = 0;
    cyc();
    period_cycles = 32'h0001_2345;
    start = 1;
    cyc();
    start = 0;
    n_chk++;
    if (tmr_chipselect !== 1'b1 || tmr_address !== 3'd2) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got cs=%b addr=%0d exp cs=1 addr=2", tmr_chipselect, tmr_address);
    end
    #2 reset_n = 0;
    #1;
    n_chk++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL rst_async: got %h exp %h", dut_vec, RESET_VEC);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      tmr_irq = i[0];
      period_update = i[1];
      cyc();
      n_chk++;
      if (tmr_chipselect !== 1'b0 || dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_no_writes%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    tmr_irq = 0;
    period_update = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 19) == 0;
      stop = $urandom_range(0, 39) == 0;
      period_update = $urandom_range(0, 14) == 0;
      tmr_irq = $urandom_range(0, 5) == 0;
      tick_ready = $urandom_range(0, 2) == 0;
      period_cycles = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
      cyc();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    {start, stop, period_update, tmr_irq} = 0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_irq_ack();
    test_overrun();
    test_stop();
    test_update();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
